// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_sweep_pkg;

  // Width of the vector index driven onto {a,b,c,d}.
  localparam int IDX_W = 4;

  // Width of the settle down-counter; holds SETTLE_CYC values up to 15.
  localparam int CNT_W = 4;

  // Golden truth tables for the reference circuit.
  // e is indexed by {a,b,c}, f = e & d is indexed by {a,b,c,d}.
  localparam logic [7:0]  EXP_E_DEF = 8'hD5;
  localparam logic [15:0] EXP_F_DEF = 16'hA222;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter that sets how long each stimulus vector is driven before sampling.
// load reloads SETTLE_CYC; expired is high during the last settle cycle.
module tt_settle_timer
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYC);

  logic [CNT_W-1:0] cnt;

  // Reload on vector entry, then count down while the vector is being driven.
  // NOTE: every clocked state update uses <= so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/tt_sweep_checker.sv
// Walks all 16 {a,b,c,d} vectors through a small combinational circuit,
// captures its e/f truth tables and compares them with the golden tables.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter int          SETTLE_CYC = 1,
  parameter logic [7:0]  EXP_E      = EXP_E_DEF,
  parameter logic [15:0] EXP_F      = EXP_F_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [3:0]  abcd_o,
  input  logic        e_i,
  input  logic        f_i,
  output logic        busy,
  output logic        done,
  output logic [7:0]  e_mask,
  output logic [15:0] f_mask,
  output logic        e_stable,
  output logic        pass
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             last_vec;
  logic             timer_load;
  logic             timer_en;
  logic             settled;

  logic [7:0]       e_mask_nxt;
  logic [15:0]      f_mask_nxt;
  logic             e_stable_nxt;
  logic             pass_nxt;

  assign last_vec   = (idx == IDX_W'(15));
  assign timer_load = ((state == ST_IDLE) && start) || ((state == ST_SAMPLE) && !last_vec);
  assign timer_en   = (state == ST_DRIVE);

  tt_settle_timer #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (settled)
  );

  // Capture values that the current SAMPLE cycle would produce, so pass can
  // include the final vector on the same edge that enters DONE.
  // NOTE: every output gets a default first, so no latch is inferred.
  always_comb begin
    e_mask_nxt      = e_mask;
    f_mask_nxt      = f_mask;
    e_stable_nxt    = e_stable;
    f_mask_nxt[idx] = f_i;
    if (!idx[0]) begin
      e_mask_nxt[idx[IDX_W-1:1]] = e_i;
    end else if (e_i != e_mask[idx[IDX_W-1:1]]) begin
      e_stable_nxt = 1'b0;
    end
    pass_nxt = (e_mask_nxt == EXP_E) && (f_mask_nxt == EXP_F) && e_stable_nxt;
  end

  // Sweep sequencer with registered stimulus, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      abcd_o   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      e_mask   <= '0;
      f_mask   <= '0;
      e_stable <= 1'b0;
      pass     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_DRIVE;
            idx      <= '0;
            abcd_o   <= '0;
            busy     <= 1'b1;
            e_mask   <= '0;
            f_mask   <= '0;
            e_stable <= 1'b1;
            pass     <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (settled) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          e_mask   <= e_mask_nxt;
          f_mask   <= f_mask_nxt;
          e_stable <= e_stable_nxt;
          if (last_vec) begin
            state  <= ST_DONE;
            abcd_o <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= pass_nxt;
          end else begin
            state  <= ST_DRIVE;
            idx    <= idx + 1'b1;
            abcd_o <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
